mult_sequencer: RTL and testbench

//  Multi-cycle signed/unsigned shift-add multiplier engine plus its sequencer for the EXE stage.
//  The controller issues EXE_MULT, and that instruction has no direct write-back.

---
 rtl/mult_sequencer_pkg.sv | 26 ++
 rtl/mult_sequencer_if.sv | 33 +++
 rtl/mult_sequencer_datapath.sv | 73 +++++++
 rtl/mult_sequencer.sv | 115 +++++++++++
 tb/tb_mult_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the EXE-stage multiply sequencer.
//   WORD_LEN         : datapath operand width
//   EXE_MULT         : EXE command code that makes the controller raise start
//   MS_BITS_PER_CYC  : default multiplier bits retired per iteration
//   MS_DEST_LEN      : default destination-tag width
//   ms_state_t       : sequencer FSM states
//   ms_iterations()  : number of BUSY iterations for a given configuration
package mult_sequencer_pkg;

    localparam int unsigned WORD_LEN        = 32;
    localparam logic [3:0]  EXE_MULT        = 4'b1001;
    localparam int unsigned MS_BITS_PER_CYC = 1;
    localparam int unsigned MS_DEST_LEN     = 5;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } ms_state_t;

    function automatic int unsigned ms_iterations(input int unsigned word_len,
                                                  input int unsigned bits_per_cyc);
        return word_len / bits_per_cyc;
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Handshake bundle between the EXE-stage controller and the multiply sequencer.
//   master : controller side (drives start/operands/flush/wb_gnt)
//   slave  : sequencer side (drives stall/busy/busy_dest/wb_req/product)
interface mult_sequencer_if #(
    parameter int unsigned WORD_LEN = mult_sequencer_pkg::WORD_LEN,
    parameter int unsigned DEST_LEN = mult_sequencer_pkg::MS_DEST_LEN
) ();

    logic                start;
    logic                is_signed;
    logic [WORD_LEN-1:0] src1;
    logic [WORD_LEN-1:0] src2;
    logic [DEST_LEN-1:0] dest_in;
    logic                flush;
    logic                wb_gnt;
    logic                stall;
    logic                busy;
    logic [DEST_LEN-1:0] busy_dest;
    logic                wb_req;
    logic [WORD_LEN-1:0] prod_hi;
    logic [WORD_LEN-1:0] prod_lo;

    modport master (
        output start, is_signed, src1, src2, dest_in, flush, wb_gnt,
        input  stall, busy, busy_dest, wb_req, prod_hi, prod_lo
    );

    modport slave (
        input  start, is_signed, src1, src2, dest_in, flush, wb_gnt,
        output stall, busy, busy_dest, wb_req, prod_hi, prod_lo
    );

endinterface

// File: rtl/mult_sequencer_datapath.sv
// Shift-add multiplier datapath: operand magnitude capture, accumulator,
// partial-product adder and final two's-complement negate.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : capture operands (magnitudes when is_signed) and clear acc
//   step          : retire BITS_PER_CYC multiplier bits
//   last          : this step is the final one; negate result if signs differ
//   out_en        : present the product (zero otherwise)
//   is_signed     : operand interpretation at load
//   src1, src2    : multiplicand, multiplier
//   prod_hi/lo    : upper/lower halves of the 2*WORD_LEN product
module mult_datapath #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                step,
    input  logic                last,
    input  logic                out_en,
    input  logic                is_signed,
    input  logic [WORD_LEN-1:0] src1,
    input  logic [WORD_LEN-1:0] src2,
    output logic [WORD_LEN-1:0] prod_hi,
    output logic [WORD_LEN-1:0] prod_lo
);

    localparam int unsigned SUM_W = WORD_LEN + BITS_PER_CYC;

    logic [WORD_LEN-1:0]     mcand;
    logic [WORD_LEN-1:0]     mplier;   // also collects low product bits as they shift in
    logic [WORD_LEN-1:0]     acc;
    logic                    neg;

    logic [WORD_LEN-1:0]     mag1;
    logic [WORD_LEN-1:0]     mag2;
    logic [BITS_PER_CYC-1:0] digit;
    logic [SUM_W-1:0]        pp;
    logic [SUM_W-1:0]        sum;
    logic [2*WORD_LEN-1:0]   shifted;
    logic [2*WORD_LEN-1:0]   result;

    always_comb begin
        // Magnitudes fit WORD_LEN bits unsigned, so -2^(W-1) stays exact.
        mag1    = (is_signed && src1[WORD_LEN-1]) ? -src1 : src1;
        mag2    = (is_signed && src2[WORD_LEN-1]) ? -src2 : src2;
        digit   = mplier[BITS_PER_CYC-1:0];
        pp      = SUM_W'(mcand) * SUM_W'(digit);
        sum     = SUM_W'(acc) + pp;
        shifted = {sum, mplier[WORD_LEN-1:BITS_PER_CYC]};
        result  = (last && neg) ? -shifted : shifted;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else if (load) begin
            mcand  <= mag1;
            mplier <= mag2;
            acc    <= '0;
            neg    <= is_signed & (src1[WORD_LEN-1] ^ src2[WORD_LEN-1]);
        end else if (step) begin
            {acc, mplier} <= result;
        end
    end

    assign prod_hi = out_en ? acc    : '0;
    assign prod_lo = out_en ? mplier : '0;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle multiply sequencer for the EXE stage. Captures operands on
// start, iterates the shift-add datapath, stalls the pipeline while busy and
// hands the 2*WORD_LEN product to HI/LO through a wb_req/wb_gnt handshake.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : controller handshake (slave side), see mult_sequencer_if
// BITS_PER_CYC must be 1, 2 or 4 and divide WORD_LEN.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int unsigned WORD_LEN     = mult_sequencer_pkg::WORD_LEN,
    parameter int unsigned BITS_PER_CYC = mult_sequencer_pkg::MS_BITS_PER_CYC,
    parameter int unsigned DEST_LEN     = mult_sequencer_pkg::MS_DEST_LEN
) (
    input  logic           clk,
    input  logic           rst,
    mult_sequencer_if.slave bus
);

    localparam int unsigned ITERS = ms_iterations(WORD_LEN, BITS_PER_CYC);
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    ms_state_t           state;
    ms_state_t           state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [DEST_LEN-1:0] dest_q;
    logic                load;
    logic                step;
    logic                last;
    logic [WORD_LEN-1:0] prod_hi;
    logic [WORD_LEN-1:0] prod_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MS_IDLE;
            cnt    <= '0;
            dest_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                dest_q <= bus.dest_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            MS_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_nxt = MS_BUSY;
                    cnt_nxt   = CNT_W'(ITERS);
                    load      = 1'b1;
                end
            end
            MS_BUSY: begin
                if (bus.flush) begin
                    state_nxt = MS_IDLE;
                end else begin
                    step    = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        last      = 1'b1;
                        state_nxt = MS_DONE;
                    end
                end
            end
            MS_DONE: begin
                // flush and grant both return to IDLE; on flush the product is dropped
                if (bus.flush || bus.wb_gnt) begin
                    state_nxt = MS_IDLE;
                end
            end
            default: begin
                state_nxt = MS_IDLE;
            end
        endcase
    end

    // stall is combinational so the issuing MULT is frozen in the cycle start is seen
    always_comb begin
        bus.stall     = (state == MS_IDLE && bus.start && !bus.flush)
                      || (state == MS_BUSY)
                      || (state == MS_DONE && !bus.wb_gnt);
        bus.busy      = (state != MS_IDLE);
        bus.busy_dest = (state != MS_IDLE) ? dest_q : '0;
        bus.wb_req    = (state == MS_DONE);
        bus.prod_hi   = prod_hi;
        bus.prod_lo   = prod_lo;
    end

    mult_datapath #(
        .WORD_LEN     (WORD_LEN),
        .BITS_PER_CYC (BITS_PER_CYC)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .last      (last),
        .out_en    (state == MS_DONE),
        .is_signed (bus.is_signed),
        .src1      (bus.src1),
        .src2      (bus.src2),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: one instance with 1 bit/cycle and one
// with 4 bits/cycle; sel chooses which instance the stimulus drives.
module tb_mult_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned D = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_sequencer_if #(.WORD_LEN(W), .DEST_LEN(D)) b1 ();
    mult_sequencer_if #(.WORD_LEN(W), .DEST_LEN(D)) b4 ();

    mult_sequencer #(.WORD_LEN(W), .BITS_PER_CYC(1), .DEST_LEN(D)) dut1 (
        .clk (clk), .rst (rst), .bus (b1)
    );
    mult_sequencer #(.WORD_LEN(W), .BITS_PER_CYC(4), .DEST_LEN(D)) dut4 (
        .clk (clk), .rst (rst), .bus (b4)
    );

    logic         sel;
    logic         start, is_signed, flush, gnt;
    logic [W-1:0] src1, src2;
    logic [D-1:0] dest;

    assign b1.start     = start & ~sel;
    assign b1.is_signed = is_signed;
    assign b1.src1      = src1;
    assign b1.src2      = src2;
    assign b1.dest_in   = dest;
    assign b1.flush     = flush & ~sel;
    assign b1.wb_gnt    = gnt & ~sel;

    assign b4.start     = start & sel;
    assign b4.is_signed = is_signed;
    assign b4.src1      = src1;
    assign b4.src2      = src2;
    assign b4.dest_in   = dest;
    assign b4.flush     = flush & sel;
    assign b4.wb_gnt    = gnt & sel;

    logic          o_stall, o_busy, o_wb_req;
    logic [D-1:0]  o_dest;
    logic [63:0]   o_prod;

    assign o_stall  = sel ? b4.stall     : b1.stall;
    assign o_busy   = sel ? b4.busy      : b1.busy;
    assign o_wb_req = sel ? b4.wb_req    : b1.wb_req;
    assign o_dest   = sel ? b4.busy_dest : b1.busy_dest;
    assign o_prod   = sel ? {b4.prod_hi, b4.prod_lo} : {b1.prod_hi, b1.prod_lo};

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // Scoreboard consumer: a product leaves the DUT when wb_req meets wb_gnt.
    always @(negedge clk) begin
        if (rst === 1'b1 && o_wb_req === 1'b1 && gnt === 1'b1) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("product", o_prod, exp_q.pop_front());
            end
        end
    end

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic [63:0] expv, input int unsigned lat,
                            input int unsigned hold, input logic [D-1:0] tag);
        int unsigned cyc;
        logic        stall_low;
        @(posedge clk); #1;
        start = 1'b1; is_signed = sgn; src1 = a; src2 = b; dest = tag;
        exp_q.push_back(expv);
        @(negedge clk);
        check("stall_on_start", 64'(o_stall), 64'd1);
        @(posedge clk); #1;
        // scramble inputs: operands must already be captured
        start = 1'b0; src1 = $urandom; src2 = $urandom; is_signed = ~sgn; dest = ~tag;
        cyc = 1; stall_low = 1'b0;
        check("busy", 64'(o_busy), 64'd1);
        check("busy_dest", 64'(o_dest), 64'(tag));
        while (o_wb_req !== 1'b1 && cyc < 200) begin
            if (o_stall !== 1'b1) stall_low = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("stall_while_busy", 64'(stall_low), 64'd0);
        repeat (hold) begin
            check("hold_req", 64'(o_wb_req), 64'd1);
            check("hold_prod", o_prod, expv);
            check("hold_stall", 64'(o_stall), 64'd1);
            @(posedge clk); #1;
        end
        gnt = 1'b1; #1;
        check("stall_on_gnt", 64'(o_stall), 64'd0);
        @(posedge clk); #1;
        gnt = 1'b0;
        check("req_drop", 64'(o_wb_req), 64'd0);
        check("idle_busy", 64'(o_busy), 64'd0);
        check("idle_dest", 64'(o_dest), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst = 1'b0; sel = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0; gnt = 1'b0;
        src1 = '0; src2 = '0; dest = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_dest", 64'(o_dest), 64'd0);
        check("rst_req", 64'(o_wb_req), 64'd0);
        check("rst_prod", o_prod, 64'd0);
        check("rst_busy4", 64'(b4.busy), 64'd0);
        @(negedge clk) rst = 1'b1;

        // 1-3 on the 1 bit/cycle instance
        run_mult(32'd7, 32'd6, 1'b0, 64'd42, 33, 0, 5'd3);
        run_mult(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 33, 0, 5'd4);
        run_mult(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 33, 0, 5'd5);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 33, 5, 5'd6);
        run_mult(32'h12345678, 32'd0, 1'b1, 64'd0, 33, 0, 5'd7);

        // start together with flush in IDLE is not accepted
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd9;
        #1 check("start_flush_stall", 64'(o_stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", 64'(o_busy), 64'd0);

        // 4: flush in cycle 10 of BUSY
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b0; src1 = 32'd11; src2 = 32'd13; dest = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_flush_busy", 64'(o_busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(o_busy), 64'd0);
        check("flush_stall", 64'(o_stall), 64'd0);
        check("flush_req", 64'(o_wb_req), 64'd0);
        @(posedge clk); #1;
        check("flush_req_later", 64'(o_wb_req), 64'd0);
        run_mult(32'd100, 32'd200, 1'b0, 64'd20000, 33, 0, 5'd10);

        // 5: async reset in cycle 20 of a multiply
        @(posedge clk); #1;
        start = 1'b1; is_signed = 1'b1; src1 = 32'hFFFF0000; src2 = 32'd77; dest = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_stall", 64'(o_stall), 64'd0);
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_dest", 64'(o_dest), 64'd0);
        check("arst_req", 64'(o_wb_req), 64'd0);
        check("arst_prod", o_prod, 64'd0);
        @(negedge clk) rst = 1'b1;
        run_mult(32'd3, 32'd4, 1'b0, 64'd12, 33, 0, 5'd18);

        // 6: 4 bits/cycle instance
        sel = 1'b1;
        run_mult(32'd7, 32'd6, 1'b0, 64'd42, 9, 0, 5'd3);
        run_mult(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 9, 0, 5'd4);
        run_mult(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 9, 0, 5'd5);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 9, 5, 5'd6);

        // random operands on both instances
        for (int i = 0; i < 8; i++) begin
            sel = (i >= 4);
            ra = $urandom; rb = $urandom; rs = 1'((i % 2) == 1);
            run_mult(ra, rb, rs, model(ra, rb, rs), (i >= 4) ? 9 : 33, 0, 5'(i + 20));
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
